// File: rtl/round_eq_pkg.sv
// round_eq_pkg: shared FSM states, default sizing and bus word-slice helper for the round checker
package round_eq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WORD_W_D     = 32;
  localparam int NUM_WORDS_D  = 4;
  localparam int MAX_ROUNDS_D = 10;
  localparam int CTR_W_D      = 8;
  // word 0 sits in the MSBs of a packed bus
  function automatic int word_lsb(input int idx, input int n, input int w);
    return (n - 1 - idx) * w;
  endfunction
endpackage

// File: rtl/round_eq_word_cmp.sv
// round_eq_word_cmp: flags inequality of one state/key word pair
module round_eq_word_cmp #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  output logic              o_ne
);
  assign o_ne = i_a != i_b;
endmodule

// File: rtl/round_eq_checker.sv
// round_eq_checker: round-windowed equivalence checker between RTL and reference cipher datapaths
module round_eq_checker
  import round_eq_pkg::*;
#(
  parameter int WORD_W     = WORD_W_D,
  parameter int NUM_WORDS  = NUM_WORDS_D,
  parameter int MAX_ROUNDS = MAX_ROUNDS_D,
  parameter int CTR_W      = CTR_W_D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        step,
  input  logic                        ref_valid,
  input  logic [NUM_WORDS*WORD_W-1:0] dut_state,
  input  logic [NUM_WORDS*WORD_W-1:0] ref_state,
  input  logic [NUM_WORDS*WORD_W-1:0] dut_key,
  input  logic [NUM_WORDS*WORD_W-1:0] ref_key,
  output logic [CTR_W-1:0]            round_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        mismatch,
  output logic                        err_sticky,
  output logic [CTR_W-1:0]            err_round,
  output logic [2*NUM_WORDS-1:0]      err_word_mask,
  output logic [CTR_W-1:0]            check_cnt,
  output logic [CTR_W-1:0]            skip_cnt
);
  state_t                 r_state, w_next;
  logic [CTR_W-1:0]       r_round, r_err_round, r_check_cnt, r_skip_cnt;
  logic                   r_mismatch, r_err_sticky;
  logic [2*NUM_WORDS-1:0] r_err_mask, w_mask;
  logic                   w_run_step, w_start, w_last, w_fail;

  // mask bit order mirrors the buses: key word 0 at the top, state word N-1 at bit 0
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_cmp
    localparam int LSB = word_lsb(g, NUM_WORDS, WORD_W);
    round_eq_word_cmp #(.WORD_W(WORD_W)) u_state (
      .i_a(dut_state[LSB+:WORD_W]), .i_b(ref_state[LSB+:WORD_W]), .o_ne(w_mask[NUM_WORDS-1-g]));
    round_eq_word_cmp #(.WORD_W(WORD_W)) u_key (
      .i_a(dut_key[LSB+:WORD_W]), .i_b(ref_key[LSB+:WORD_W]), .o_ne(w_mask[2*NUM_WORDS-1-g]));
  end

  assign w_run_step = r_state == RUN && step;
  assign w_start    = start && r_state != RUN;
  assign w_last     = w_run_step && r_round == CTR_W'(MAX_ROUNDS);
  assign w_fail     = w_run_step && ref_valid && |w_mask;

  // next state: start leaves IDLE/DONE, the step on the last round ends the run
  always_comb begin
    w_next = r_state;
    w_next = w_start ? RUN : w_last ? DONE : w_next;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // round counter, compare/skip counters and first-failure capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_round      <= '0;
      r_check_cnt  <= '0;
      r_skip_cnt   <= '0;
      r_mismatch   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_round  <= '0;
      r_err_mask   <= '0;
    end else begin
      r_mismatch <= w_fail;
      if (w_start) begin
        r_round      <= CTR_W'(1);
        r_check_cnt  <= '0;
        r_skip_cnt   <= '0;
        r_err_sticky <= 1'b0;
        r_err_round  <= '0;
        r_err_mask   <= '0;
      end else if (w_run_step) begin
        if (!w_last) r_round <= r_round + 1'b1;
        if (ref_valid) r_check_cnt <= &r_check_cnt ? r_check_cnt : r_check_cnt + 1'b1;
        else           r_skip_cnt  <= &r_skip_cnt ? r_skip_cnt : r_skip_cnt + 1'b1;
        if (w_fail && !r_err_sticky) begin
          r_err_sticky <= 1'b1;
          r_err_round  <= r_round;
          r_err_mask   <= w_mask;
        end
      end
    end
  end

  assign round_idx     = r_round;
  assign busy          = r_state == RUN;
  assign done          = r_state == DONE;
  assign mismatch      = r_mismatch;
  assign err_sticky    = r_err_sticky;
  assign err_round     = r_err_round;
  assign err_word_mask = r_err_mask;
  assign check_cnt     = r_check_cnt;
  assign skip_cnt      = r_skip_cnt;
endmodule
